reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the display register block (addr[2:0]/write/data_in[7:0]) among several producers, e.g. the CAN decoder, battery monitor and GPS interface. It accepts one write per cycle through per-requester valid/ready handshakes and drives a registered write onto the register block. Addresses the register block does not decode are filtered and counted. When the register block is idle, its address is parked on an undecoded slot.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PARK_ADDR, 3'b111, address driven when no write is in flight (undecoded by register block)
TIMEOUT_CYCLES, 5000000, watchdog period in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  bit i: requester i has a write pending
req_addr  in  3*NUM_REQ  requester i address in bits [3i+2:3i]
req_data  in  8*NUM_REQ  requester i data in bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
addr  out  3  register block address (registered)
write  out  1  register block write strobe (registered, one cycle per write)
data_out  out  8  register block data (registered)
drop_count  out  8  saturating count of dropped writes to invalid addresses
stale_pulse  out  1  one-cycle watchdog pulse (present only with STALE_WDT_EN)

Behaviour:
- Reset (rst_n low, async): addr=PARK_ADDR, write=0, data_out=0, drop_count=0, rr_ptr=0, req_ready=0. Any write in flight is discarded.
- req_ready is combinational from req_valid and rr_ptr, and is forced to 0 while rst_n is low.
- Grant selection:
  - The first valid requester searching from rr_ptr upward, modulo NUM_REQ, is granted.
  - At most one req_ready bit is high per cycle.
  - A requester with valid low never gets ready.
- After a grant to requester i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Latency:
  - Transfer accepted in cycle N drives addr/data_out/write=1 in cycle N+1.
  - Throughput is one write per cycle, so back-to-back grants produce back-to-back write strobes.
- Idle: in any cycle after a cycle with no accepted valid write, write=0, addr=PARK_ADDR, and data_out holds its last value.
- Valid addresses are 3'b000..3'b101.
  - A granted transfer with addr 3'b110 or 3'b111 is still accepted: ready is asserted and the pointer advances.
  - It produces no write strobe; addr stays PARK_ADDR.
  - drop_count increments by 1 and saturates at 8'hFF.
- Requesters must hold valid/addr/data stable until ready. Deasserting valid before ready is permitted, and the request is then lost.
- Widths: no arithmetic on data, which passes through unmodified. rr_ptr is ceil(log2(NUM_REQ)) bits, and wrap is explicit for non-power-of-2 NUM_REQ.

Optional Feature:
Macro STALE_WDT_EN.
- With STALE_WDT_EN:
  - A 32-bit counter increments every cycle and clears on any issued write to addr 3'b000 (speed).
  - When the counter reaches TIMEOUT_CYCLES-1, an injection is pending.
  - In the next cycle the injection takes priority: all req_ready=0 and rr_ptr holds.
  - The following cycle drives addr=3'b000, data_out=8'h00, write=1, with stale_pulse=1 for that cycle only.
  - The counter then restarts from 0.
  - Reset clears both the counter and the pending injection.
- Without STALE_WDT_EN: no counter, no stale_pulse port, and grant logic is never blocked.

Test Plan:
- Reset/idle: assert rst_n=0 mid-write with write=1 -> same cycle write=0, addr=3'b111, drop_count=0; after release with no valid, outputs stay parked.
- Single requester: req 1 valid, addr 3'b010, data 8'h5A -> req_ready=3'b010 in cycle N; cycle N+1 addr=3'b010, data_out=8'h5A, write=1; cycle N+2 write=0, addr=3'b111.
- Contention: all 3 valid continuously, each with distinct addr -> grant order 0,1,2,0,1,2; six consecutive write strobes with the matching addr/data.
- Invalid address: req 0 sends addr 3'b110 260 times -> no write strobe ever, drop_count saturates at 8'hFF, ready asserted each time.
- Held request under contention: req 2 valid alone, then req 0 joins while rr_ptr=0 -> req 0 granted first and req 2 the next cycle; req 2's data is unchanged at its issue.
- Watchdog (STALE_WDT_EN, TIMEOUT_CYCLES=16): no speed writes for 16 cycles with req 1 valid -> one cycle with req_ready=0, then addr=3'b000, data_out=8'h00, write=1, stale_pulse=1; a speed write at cycle 10 instead prevents injection.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter_if
//
// Purpose: groups the producer handshake signals and the register-block write
// port of the round-robin register write arbiter into a single bundle.
//
// Signals:
//   req_valid   [NUM_REQ]    producer i has a write pending
//   req_addr    [3*NUM_REQ]  producer i address in bits [3i+2:3i]
//   req_data    [8*NUM_REQ]  producer i data in bits [8i+7:8i]
//   req_ready   [NUM_REQ]    one-hot grant back to the producers
//   addr        [3]          register block address (registered)
//   write       [1]          register block write strobe (registered)
//   data_out    [8]          register block data (registered)
//   drop_count  [8]          saturating count of writes to undecoded addresses
//   stale_pulse [1]          watchdog injection marker (only with STALE_WDT_EN)
//
// Modports:
//   master : the producer / register-block side (testbench or system glue)
//   slave  : the arbiter itself
//
// Optional feature macro: STALE_WDT_EN adds the stale_pulse signal.
// ---------------------------------------------------------------------------
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           addr;
  logic                 write;
  logic [7:0]           data_out;
  logic [7:0]           drop_count;
`ifdef STALE_WDT_EN
  logic                 stale_pulse;
`endif

`ifdef STALE_WDT_EN
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, addr, write, data_out, drop_count, stale_pulse
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, addr, write, data_out, drop_count, stale_pulse
  );
`else
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, addr, write, data_out, drop_count
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, addr, write, data_out, drop_count
  );
`endif

endinterface

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose: round-robin arbiter sharing the single write port of the display
// register block (addr/write/data) among NUM_REQ producers such as the CAN
// decoder, battery monitor and GPS interface. One transfer per cycle is
// accepted through per-producer valid/ready handshakes and is presented to
// the register block one cycle later as a registered write. Writes aimed at
// addresses the register block does not decode (3'b110, 3'b111) are accepted
// but swallowed and counted. While idle the address output parks on
// PARK_ADDR so the register block never sees a stray decode.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : reg_write_arbiter_if.slave (producer handshakes + write port)
//
// Parameters:
//   NUM_REQ        : number of producers (2..8)
//   PARK_ADDR      : address driven when no write is in flight
//   TIMEOUT_CYCLES : stale-speed watchdog period in clk cycles
//
// Optional feature macro: STALE_WDT_EN
//   Adds a watchdog that injects a zero write to the speed register (addr 0)
//   when no speed write has been issued for TIMEOUT_CYCLES cycles, flagged
//   by a one-cycle stale_pulse.
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int         NUM_REQ        = 3,
  parameter logic [2:0] PARK_ADDR      = 3'b111,
  parameter int         TIMEOUT_CYCLES = 5000000
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rrPtr_q;
  logic [PTR_W-1:0] rrPtr_d;
  logic [PTR_W-1:0] grantIdx;
  logic             grantFound;
  logic             blockGrant;
  logic             inject;
  logic             accepted;
  logic [2:0]       grantAddr;
  logic [7:0]       grantData;
  logic             addrValid;
  logic [NUM_REQ-1:0] grant;

  logic [2:0]       addr_q;
  logic             write_q;
  logic [7:0]       dataOut_q;
  logic [7:0]       dropCount_q;

  // Search the valid vector starting at the round-robin pointer and wrapping
  // explicitly at NUM_REQ, so non-power-of-two requester counts never index
  // past the last real requester. The first hit wins, which keeps the grant
  // one-hot; a requester without valid can never be picked. The grant is
  // suppressed during reset and while a watchdog injection owns the port.
  always_comb begin
    int idx;
    grant      = '0;
    grantIdx   = '0;
    grantFound = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grantFound && bus.req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = PTR_W'(idx);
      end
    end
    if (grantFound && rst_n && !blockGrant) begin
      grant[grantIdx] = 1'b1;
    end
  end

  assign bus.req_ready = grant;
  assign accepted      = grantFound && rst_n && !blockGrant;
  assign grantAddr     = bus.req_addr[int'(grantIdx)*3 +: 3];
  assign grantData     = bus.req_data[int'(grantIdx)*8 +: 8];
  assign addrValid     = (grantAddr <= 3'b101);

  // The pointer moves just past the requester that was served, wrapping back
  // to zero after the last one. Without an accepted transfer it holds, so a
  // waiting requester keeps its place in the rotation.
  always_comb begin
    int nextIdx;
    nextIdx = int'(grantIdx) + 1;
    if (nextIdx >= NUM_REQ) begin
      nextIdx = 0;
    end
    rrPtr_d = accepted ? PTR_W'(nextIdx) : rrPtr_q;
  end

`ifdef STALE_WDT_EN
  logic [31:0] wdtCount_q;
  logic        injectPending_q;
  logic        stalePulse_q;
  logic        speedIssue;

  assign speedIssue     = accepted && addrValid && (grantAddr == 3'b000);
  assign blockGrant     = injectPending_q;
  assign inject         = injectPending_q;
  assign bus.stale_pulse = stalePulse_q;

  // Watchdog: counts cycles since the last speed write was issued. Hitting
  // TIMEOUT_CYCLES-1 arms an injection; the armed cycle blocks all grants and
  // issues the zero speed write itself, which also restarts the count. A real
  // speed write issued in the same cycle the count expires takes precedence,
  // since the register is then fresh and no injection is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdtCount_q      <= '0;
      injectPending_q <= 1'b0;
      stalePulse_q    <= 1'b0;
    end else begin
      stalePulse_q <= injectPending_q;
      if (injectPending_q) begin
        wdtCount_q      <= '0;
        injectPending_q <= 1'b0;
      end else if (speedIssue) begin
        wdtCount_q <= '0;
      end else begin
        if (wdtCount_q == 32'(TIMEOUT_CYCLES - 1)) begin
          injectPending_q <= 1'b1;
        end
        wdtCount_q <= wdtCount_q + 32'd1;
      end
    end
  end
`else
  logic unusedTimeout;

  // The watchdog period only matters when the watchdog is built in.
  assign unusedTimeout = (TIMEOUT_CYCLES > 0);
  assign blockGrant    = 1'b0;
  assign inject        = 1'b0;
`endif

  // Register-block write port. An accepted transfer to a decoded address is
  // replayed one cycle later with a single-cycle strobe, so back-to-back
  // grants give back-to-back strobes. Anything else (idle cycle or a
  // swallowed undecoded write) parks the address and drops the strobe while
  // data_out keeps its last value. Swallowed writes bump a saturating
  // counter so a misbehaving producer is visible without wrapping to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q     <= '0;
      addr_q      <= PARK_ADDR;
      write_q     <= 1'b0;
      dataOut_q   <= 8'h00;
      dropCount_q <= 8'h00;
    end else begin
      rrPtr_q <= rrPtr_d;
      if (inject) begin
        addr_q    <= 3'b000;
        dataOut_q <= 8'h00;
        write_q   <= 1'b1;
      end else if (accepted && addrValid) begin
        addr_q    <= grantAddr;
        dataOut_q <= grantData;
        write_q   <= 1'b1;
      end else begin
        addr_q  <= PARK_ADDR;
        write_q <= 1'b0;
      end
      if (accepted && !addrValid && (dropCount_q != 8'hFF)) begin
        dropCount_q <= dropCount_q + 8'd1;
      end
    end
  end

  assign bus.addr       = addr_q;
  assign bus.write      = write_q;
  assign bus.data_out   = dataOut_q;
  assign bus.drop_count = dropCount_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Purpose: self-checking bench for reg_write_arbiter with NUM_REQ=3. A small
// behavioural model of the round-robin grant, drop counter and (optionally)
// the stale-speed watchdog pushes the expected register-block outputs into a
// scoreboard queue when stimulus is applied; each following cycle the front
// entry is popped and compared against the DUT.
//
// Optional feature macro: STALE_WDT_EN (watchdog scenarios, TIMEOUT=16).
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int         NUM_REQ = 3;
  localparam logic [2:0] PARK    = 3'b111;
`ifdef STALE_WDT_EN
  localparam int         TIMEOUT = 16;
`else
  localparam int         TIMEOUT = 5000000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  reg_write_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PARK_ADDR(PARK),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] dc;
    logic       st;
  } exp_t;

  exp_t sbq[$];
  int   nVec  = 0;
  int   nFail = 0;

  int         mPtr;
  logic [7:0] mDrop;
  logic [7:0] mData;
  int         mCnt;
  bit         mPend;

  // Hold the DUT in reset for two cycles and clear the reference model.
  task automatic doReset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    sbq.delete();
    mPtr  = 0;
    mDrop = 8'h00;
    mData = 8'h00;
    mCnt  = 0;
    mPend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply one cycle of requests, compute the expected one-hot ready and push
  // the output the register block should see on the next cycle.
  task automatic drive(input logic [2:0] v, input logic [8:0] a,
                       input logic [23:0] d, output logic [2:0] er);
    exp_t       e;
    int         g;
    logic [2:0] ga;
    logic [7:0] gd;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    er   = '0;
    e.w  = 1'b0;
    e.a  = PARK;
    e.st = 1'b0;
    ga   = 3'b111;
    gd   = 8'h00;
    g    = -1;
    if (mPend) begin
      e.w   = 1'b1;
      e.a   = 3'b000;
      e.st  = 1'b1;
      mData = 8'h00;
      mPend = 1'b0;
      mCnt  = 0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (mPtr + k) % NUM_REQ;
        if (g < 0 && v[i]) g = i;
      end
      if (g >= 0) begin
        er[g] = 1'b1;
        ga    = a[3*g +: 3];
        gd    = d[8*g +: 8];
        mPtr  = (g + 1) % NUM_REQ;
        if (ga <= 3'b101) begin
          e.w   = 1'b1;
          e.a   = ga;
          mData = gd;
        end else if (mDrop != 8'hFF) begin
          mDrop = mDrop + 8'd1;
        end
      end
`ifdef STALE_WDT_EN
      if (g >= 0 && ga == 3'b000) begin
        mCnt = 0;
      end else begin
        if (mCnt == TIMEOUT - 1) mPend = 1'b1;
        mCnt = mCnt + 1;
      end
`endif
    end
    e.d  = mData;
    e.dc = mDrop;
    sbq.push_back(e);
  endtask

  // Reset mid-write forces the port idle at once; afterwards it stays parked.
  task automatic test_reset();
    logic [2:0] er;
    exp_t       e;
    doReset();
    drive(3'b010, {3'b000, 3'b010, 3'b000}, {8'h00, 8'h5A, 8'h00}, er);
    #1;
    nVec++;
    if (bus.req_ready !== er) begin
      nFail++;
      $display("[TB] FAIL reset_pre_ready got %b want %b", bus.req_ready, er);
    end
    @(negedge clk);
    e = sbq.pop_front();
    nVec++;
    if (bus.write !== 1'b1 || bus.addr !== 3'b010) begin
      nFail++;
      $display("[TB] FAIL reset_pre_write got w=%b a=%h want w=1 a=2", bus.write, bus.addr);
    end
    rst_n = 1'b0;
    #1;
    nVec++;
    if (bus.write !== 1'b0 || bus.addr !== PARK || bus.drop_count !== 8'h00 ||
        bus.data_out !== 8'h00 || bus.req_ready !== 3'b000) begin
      nFail++;
      $display("[TB] FAIL reset_async got w=%b a=%h d=%h dc=%h rdy=%b want w=0 a=7 d=0 dc=0 rdy=0",
               bus.write, bus.addr, bus.data_out, bus.drop_count, bus.req_ready);
    end
    doReset();
    for (int c = 0; c < 3; c++) begin
      drive(3'b000, 9'h000, 24'h000000, er);
      #1;
      nVec++;
      if (bus.req_ready !== er) begin
        nFail++;
        $display("[TB] FAIL reset_idle_ready got %b want %b", bus.req_ready, er);
      end
      @(negedge clk);
      e = sbq.pop_front();
      nVec++;
      if ({bus.write, bus.addr, bus.data_out, bus.drop_count} !== {e.w, e.a, e.d, e.dc}) begin
        nFail++;
        $display("[TB] FAIL reset_idle_out got w=%b a=%h d=%h dc=%h want w=%b a=%h d=%h dc=%h",
                 bus.write, bus.addr, bus.data_out, bus.drop_count, e.w, e.a, e.d, e.dc);
      end
    end
  endtask

  // One requester: ready in cycle N, write in N+1, parked again in N+2.
  task automatic test_single();
    logic [2:0]  er;
    exp_t        e;
    logic [2:0]  vTab [2];
    logic [2:0]  rTab [2];
    logic [11:0] oTab [2];
    vTab[0] = 3'b010; rTab[0] = 3'b010; oTab[0] = {1'b1, 3'b010, 8'h5A};
    vTab[1] = 3'b000; rTab[1] = 3'b000; oTab[1] = {1'b0, 3'b111, 8'h5A};
    doReset();
    for (int c = 0; c < 2; c++) begin
      drive(vTab[c], {3'b000, 3'b010, 3'b000}, {8'h00, 8'h5A, 8'h00}, er);
      #1;
      nVec++;
      if (bus.req_ready !== rTab[c]) begin
        nFail++;
        $display("[TB] FAIL single_ready[%0d] got %b want %b", c, bus.req_ready, rTab[c]);
      end
      @(negedge clk);
      e = sbq.pop_front();
      nVec++;
      if ({bus.write, bus.addr, bus.data_out} !== oTab[c] ||
          {bus.write, bus.addr, bus.data_out} !== {e.w, e.a, e.d}) begin
        nFail++;
        $display("[TB] FAIL single_out[%0d] got %h want %h", c,
                 {bus.write, bus.addr, bus.data_out}, oTab[c]);
      end
    end
  endtask

  // Everyone valid: grants rotate 0,1,2,... with six consecutive strobes.
  task automatic test_contention();
    logic [2:0] er;
    exp_t       e;
    logic [2:0] want;
    doReset();
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, {3'b101, 3'b011, 3'b001}, {8'hC3, 8'hB2, 8'hA1}, er);
      want = 3'b001 << (c % 3);
      #1;
      nVec++;
      if (bus.req_ready !== want || er !== want) begin
        nFail++;
        $display("[TB] FAIL contention_grant[%0d] got %b want %b", c, bus.req_ready, want);
      end
      @(negedge clk);
      e = sbq.pop_front();
      nVec++;
      if ({bus.write, bus.addr, bus.data_out} !== {e.w, e.a, e.d}) begin
        nFail++;
        $display("[TB] FAIL contention_out[%0d] got w=%b a=%h d=%h want w=%b a=%h d=%h",
                 c, bus.write, bus.addr, bus.data_out, e.w, e.a, e.d);
      end
    end
  endtask

  // Undecoded address: always accepted, never written, counter saturates.
  task automatic test_invalid_addr();
    logic [2:0] er;
    exp_t       e;
    int         strobes;
    strobes = 0;
    doReset();
    for (int c = 0; c < 260; c++) begin
      drive(3'b001, {3'b000, 3'b000, 3'b110}, {8'h00, 8'h00, 8'(c)}, er);
      #1;
      nVec++;
      if (bus.req_ready !== 3'b001) begin
        nFail++;
        $display("[TB] FAIL invalid_ready[%0d] got %b want 001", c, bus.req_ready);
      end
      @(negedge clk);
      e = sbq.pop_front();
      if (bus.write !== 1'b0) strobes++;
      nVec++;
      if ({bus.write, bus.addr, bus.drop_count} !== {e.w, e.a, e.dc}) begin
        nFail++;
        $display("[TB] FAIL invalid_out[%0d] got w=%b a=%h dc=%h want w=%b a=%h dc=%h",
                 c, bus.write, bus.addr, bus.drop_count, e.w, e.a, e.dc);
      end
    end
    nVec++;
    if (bus.drop_count !== 8'hFF || strobes != 0) begin
      nFail++;
      $display("[TB] FAIL invalid_final got dc=%h strobes=%0d want dc=ff strobes=0",
               bus.drop_count, strobes);
    end
  endtask

  // Req 2 alone, then req 0 joins with the pointer back at 0: 0 wins, then 2.
  task automatic test_held_request();
    logic [2:0]  er;
    exp_t        e;
    logic [2:0]  vTab [3];
    logic [2:0]  rTab [3];
    logic [10:0] oTab [3];
    vTab[0] = 3'b100; rTab[0] = 3'b100; oTab[0] = {3'b100, 8'h77};
    vTab[1] = 3'b101; rTab[1] = 3'b001; oTab[1] = {3'b011, 8'h33};
    vTab[2] = 3'b100; rTab[2] = 3'b100; oTab[2] = {3'b100, 8'h77};
    doReset();
    for (int c = 0; c < 3; c++) begin
      drive(vTab[c], {3'b100, 3'b000, 3'b011}, {8'h77, 8'h00, 8'h33}, er);
      #1;
      nVec++;
      if (bus.req_ready !== rTab[c] || er !== rTab[c]) begin
        nFail++;
        $display("[TB] FAIL held_ready[%0d] got %b want %b", c, bus.req_ready, rTab[c]);
      end
      @(negedge clk);
      e = sbq.pop_front();
      nVec++;
      if (bus.write !== 1'b1 || {bus.addr, bus.data_out} !== oTab[c] ||
          {bus.addr, bus.data_out} !== {e.a, e.d}) begin
        nFail++;
        $display("[TB] FAIL held_out[%0d] got w=%b a/d=%h want w=1 a/d=%h",
                 c, bus.write, {bus.addr, bus.data_out}, oTab[c]);
      end
    end
  endtask

  // Random valid patterns, addresses and data against the reference model.
  task automatic test_random();
    logic [2:0] er;
    exp_t       e;
    doReset();
    for (int c = 0; c < 200; c++) begin
      drive(3'($urandom_range(0, 7)), 9'($urandom), 24'($urandom), er);
      #1;
      nVec++;
      if (bus.req_ready !== er) begin
        nFail++;
        $display("[TB] FAIL random_ready[%0d] got %b want %b", c, bus.req_ready, er);
      end
      @(negedge clk);
      e = sbq.pop_front();
      nVec++;
      if ({bus.write, bus.addr, bus.data_out, bus.drop_count} !== {e.w, e.a, e.d, e.dc}) begin
        nFail++;
        $display("[TB] FAIL random_out[%0d] got w=%b a=%h d=%h dc=%h want w=%b a=%h d=%h dc=%h",
                 c, bus.write, bus.addr, bus.data_out, bus.drop_count, e.w, e.a, e.d, e.dc);
      end
`ifdef STALE_WDT_EN
      nVec++;
      if (bus.stale_pulse !== e.st) begin
        nFail++;
        $display("[TB] FAIL random_stale[%0d] got %b want %b", c, bus.stale_pulse, e.st);
      end
`endif
    end
  endtask

`ifdef STALE_WDT_EN
  // No speed writes for 16 cycles: one blocked cycle, then the zero injection.
  // A speed write at cycle 10 instead keeps the injection away.
  task automatic test_watchdog();
    logic [2:0] er;
    exp_t       e;
    int         staleSeen;
    for (int run = 0; run < 2; run++) begin
      staleSeen = 0;
      doReset();
      for (int c = 0; c < ((run == 0) ? 20 : 26); c++) begin
        if (run == 1 && c == 10)
          drive(3'b010, {3'b000, 3'b000, 3'b000}, {8'h00, 8'h99, 8'h00}, er);
        else
          drive(3'b010, {3'b000, 3'b001, 3'b000}, {8'h00, 8'(c), 8'h00}, er);
        #1;
        nVec++;
        if (bus.req_ready !== er || (run == 0 && c == 16 && bus.req_ready !== 3'b000)) begin
          nFail++;
          $display("[TB] FAIL wdt_ready[%0d.%0d] got %b want %b", run, c, bus.req_ready, er);
        end
        @(negedge clk);
        e = sbq.pop_front();
        if (bus.stale_pulse === 1'b1) staleSeen++;
        nVec++;
        if ({bus.write, bus.addr, bus.data_out, bus.stale_pulse} !== {e.w, e.a, e.d, e.st}) begin
          nFail++;
          $display("[TB] FAIL wdt_out[%0d.%0d] got w=%b a=%h d=%h st=%b want w=%b a=%h d=%h st=%b",
                   run, c, bus.write, bus.addr, bus.data_out, bus.stale_pulse,
                   e.w, e.a, e.d, e.st);
        end
        if (run == 0 && c == 16) begin
          nVec++;
          if ({bus.write, bus.addr, bus.data_out, bus.stale_pulse} !== {1'b1, 3'b000, 8'h00, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL wdt_inject got w=%b a=%h d=%h st=%b want w=1 a=0 d=0 st=1",
                     bus.write, bus.addr, bus.data_out, bus.stale_pulse);
          end
        end
      end
      nVec++;
      if (staleSeen != ((run == 0) ? 1 : 0)) begin
        nFail++;
        $display("[TB] FAIL wdt_count[%0d] got %0d pulses want %0d", run, staleSeen,
                 (run == 0) ? 1 : 0);
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] reg_write_arbiter bench start");
    test_reset();
    test_single();
    test_contention();
    test_invalid_addr();
    test_held_request();
    test_random();
`ifdef STALE_WDT_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
